hazard_stall_controller: RTL and testbench

Central pipeline sequencer for the five-stage core. Drives the `enable` and active-low `Sync_Reset` inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers to freeze stages or inject bubbles. It covers load-use hazards, taken branches, jumps, multi-cycle multiply/divide (MDU) occupancy and a debug halt/drain handshake. It is a Mealy controller: outputs are combinational from registered state plus current hazard inputs.

---
 rtl/hazard_stall_controller_pkg.sv | 82 ++++++++
 rtl/hazard_stall_controller_counter.sv | 37 +++
 rtl/hazard_stall_controller.sv | 209 ++++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_pkg
//
// Shared definitions for the pipeline hazard/stall sequencer:
//   - CNT_W       : width of the MDU and drain stall counters
//   - state_t     : sequencer states (RUN=0, MDU_BUSY=1, DRAIN=2, HALTED=3)
//   - ctrl_t      : bundle of all pipeline-register control outputs
//   - event_ctrl  : maps the prioritised hazard events of one cycle onto
//                   the control bundle, including the drain overrides
// ---------------------------------------------------------------------------
package hazard_stall_controller_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_sr;
        logic idex_sr;
        logic exmem_sr;
        logic memwb_sr;
        logic halt_ack;
    } ctrl_t;

    // Free-running pipeline: everything loads, nothing is cleared.
    localparam ctrl_t CTRL_IDLE   = ctrl_t'(10'b11111_1111_0);
    // Fully frozen, empty pipeline waiting on the debugger.
    localparam ctrl_t CTRL_HALTED = ctrl_t'(10'b00000_1111_1);

    // Only the highest-priority event shapes the outputs. The caller passes
    // 'mdu' already qualified (latency > 1 and not masked).
    function automatic ctrl_t event_ctrl(
        input logic in_drain,
        input logic mdu,
        input logic branch,
        input logic load_use,
        input logic jump
    );
        ctrl_t c;
        c = CTRL_IDLE;
        if (mdu) begin
            // Hold everything up to EX/MEM; feed a bubble into MEM/WB.
            c.pc_en    = 1'b0;
            c.ifid_en  = 1'b0;
            c.idex_en  = 1'b0;
            c.exmem_en = 1'b0;
            c.memwb_sr = 1'b0;
        end else if (branch) begin
            c.ifid_sr = 1'b0;
            c.idex_sr = 1'b0;
        end else if (load_use) begin
            c.pc_en   = 1'b0;
            c.ifid_en = 1'b0;
            c.idex_sr = 1'b0;
        end else if (jump) begin
            c.ifid_sr = 1'b0;
        end

        if (in_drain) begin
            // Draining: stop fetching (a taken branch still redirects the PC
            // so the resume address is correct) and push only bubbles into ID.
            if (mdu || !branch) begin
                c.pc_en = 1'b0;
            end
            if (c.ifid_en) begin
                c.ifid_sr = 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_counter.sv
// ---------------------------------------------------------------------------
// stall_cycle_counter
//
// Loadable down-counter used for MDU occupancy and drain length.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low; clears the count
//   load       : load 'load_value' (takes priority over dec)
//   load_value : value to load
//   dec        : decrement by one; holds at zero
//   count      : current count
//   zero       : count == 0
// ---------------------------------------------------------------------------
module stall_cycle_counter
    import hazard_stall_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Central Mealy sequencer for the five-stage core. Drives the load enables
// and active-low synchronous clears of the PC and the four pipeline
// registers to resolve load-use hazards, taken branches, jumps, multi-cycle
// MDU occupancy and a debug halt/drain handshake.
//
// Parameters:
//   MDU_LATENCY    : cycles an MDU op occupies EX (1..15)
//   DRAIN_CYCLES   : advancing bubble cycles before halt_ack (1..15)
//   REG_ADDR_WIDTH : register-file address width
// Ports:
//   clk, reset                  : clock; asynchronous active-low reset
//   ifid_rs/ifid_rt/ifid_uses_rt: sources of the instruction in ID
//   ifid_jump                   : ID instruction is J/JAL/JR
//   idex_mem_read, idex_rt      : EX instruction is a load, and its dest
//   idex_mdu_start              : EX instruction is MULT/DIV
//   ex_branch_taken             : branch in EX resolved taken
//   halt_req                    : debug halt request (level)
//   *_enable                    : register load enables
//   *_sync_reset                : 0 clears the register when enabled
//   halt_ack                    : pipeline empty and frozen
// ---------------------------------------------------------------------------
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MDU_LATENCY    = 4,
    parameter int DRAIN_CYCLES   = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rt,
    input  logic                      ifid_uses_rt,
    input  logic                      ifid_jump,
    input  logic                      idex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rt,
    input  logic                      idex_mdu_start,
    input  logic                      ex_branch_taken,
    input  logic                      halt_req,
    output logic                      pc_enable,
    output logic                      ifid_enable,
    output logic                      idex_enable,
    output logic                      exmem_enable,
    output logic                      memwb_enable,
    output logic                      ifid_sync_reset,
    output logic                      idex_sync_reset,
    output logic                      exmem_sync_reset,
    output logic                      memwb_sync_reset,
    output logic                      halt_ack
);

    // MDU_LATENCY = 1 never stalls; the first stall cycle is spent in the
    // issuing state, so the counter covers the remaining MDU_LATENCY-2.
    localparam logic             MDU_STALLS = (MDU_LATENCY > 1);
    localparam logic [CNT_W-1:0] MDU_LOAD   =
        (MDU_LATENCY > 1) ? CNT_W'(MDU_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    state_t state;
    state_t next_state;
    logic   ret_drain;        // 1: return to DRAIN after MDU, 0: RUN
    logic   ret_drain_next;

    logic             mdu_load;
    logic             mdu_dec;
    logic [CNT_W-1:0] mdu_cnt;
    logic             mdu_zero;
    logic             drain_load;
    logic             drain_dec;
    logic [CNT_W-1:0] drain_cnt;
    logic             drain_zero;
    logic             drain_advance;

    logic  load_use;
    logic  mdu_evt;
    ctrl_t ctrl;
    ctrl_t ctrl_out;

    assign load_use = idex_mem_read && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) ||
                       (ifid_uses_rt && (idex_rt == ifid_rt)));

    assign mdu_evt = idex_mdu_start && MDU_STALLS;

    stall_cycle_counter u_mdu_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (mdu_load),
        .load_value (MDU_LOAD),
        .dec        (mdu_dec),
        .count      (mdu_cnt),
        .zero       (mdu_zero)
    );

    stall_cycle_counter u_drain_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (drain_load),
        .load_value (DRAIN_LOAD),
        .dec        (drain_dec),
        .count      (drain_cnt),
        .zero       (drain_zero)
    );

    // The MDU release decision only needs the zero flag.
    logic unused_mdu_cnt;
    assign unused_mdu_cnt = ^mdu_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            ret_drain <= 1'b0;
        end else begin
            state     <= next_state;
            ret_drain <= ret_drain_next;
        end
    end

    always_comb begin
        next_state     = state;
        ret_drain_next = ret_drain;
        mdu_load       = 1'b0;
        mdu_dec        = 1'b0;
        drain_load     = 1'b0;
        drain_dec      = 1'b0;
        drain_advance  = 1'b0;
        ctrl           = CTRL_IDLE;

        case (state)
            RUN: begin
                ctrl = event_ctrl(1'b0, mdu_evt, ex_branch_taken, load_use, ifid_jump);
                if (mdu_evt) begin
                    next_state     = MDU_BUSY;
                    mdu_load       = 1'b1;
                    ret_drain_next = 1'b0;
                end else if (halt_req) begin
                    next_state = DRAIN;
                    drain_load = 1'b1;
                end
            end

            DRAIN: begin
                ctrl = event_ctrl(1'b1, mdu_evt, ex_branch_taken, load_use, ifid_jump);
                if (mdu_evt) begin
                    next_state     = MDU_BUSY;
                    mdu_load       = 1'b1;
                    ret_drain_next = 1'b1;
                end else begin
                    // A load-use bubble does not advance the pipeline.
                    drain_advance = !load_use;
                end
            end

            MDU_BUSY: begin
                if (!mdu_zero) begin
                    ctrl    = event_ctrl(ret_drain, 1'b1, 1'b0, 1'b0, 1'b0);
                    mdu_dec = 1'b1;
                end else begin
                    // Last EX cycle of the MDU op: behave like the return
                    // state, but the still-asserted mdu start must not
                    // re-trigger the stall.
                    ctrl       = event_ctrl(ret_drain, 1'b0, ex_branch_taken,
                                            load_use, ifid_jump);
                    next_state = ret_drain ? DRAIN : RUN;
                    if (ret_drain) begin
                        drain_advance = !load_use;
                    end
                end
            end

            HALTED: begin
                ctrl = CTRL_HALTED;
                if (!halt_req) begin
                    next_state = RUN;
                end
            end

            default: begin
                next_state = RUN;
            end
        endcase

        if (drain_advance) begin
            drain_dec = 1'b1;
            if ((drain_cnt == CNT_W'(1)) || drain_zero) begin
                next_state = HALTED;
            end
        end
    end

    // While reset is held the outputs sit at their reset values regardless
    // of what the hazard inputs are doing.
    assign ctrl_out = reset ? ctrl : CTRL_IDLE;

    assign pc_enable        = ctrl_out.pc_en;
    assign ifid_enable      = ctrl_out.ifid_en;
    assign idex_enable      = ctrl_out.idex_en;
    assign exmem_enable     = ctrl_out.exmem_en;
    assign memwb_enable     = ctrl_out.memwb_en;
    assign ifid_sync_reset  = ctrl_out.ifid_sr;
    assign idex_sync_reset  = ctrl_out.idex_sr;
    assign exmem_sync_reset = ctrl_out.exmem_sr;
    assign memwb_sync_reset = ctrl_out.memwb_sr;
    assign halt_ack         = ctrl_out.halt_ack;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller
//
// Directed stimulus with hand-computed expected control vectors. The driver
// pushes each cycle's expected vector into a scoreboard queue; a monitor on
// the falling edge pops and compares against the DUT outputs.
// Vector bit order: {pc, ifid, idex, exmem, memwb enables,
//                    ifid, idex, exmem, memwb sync_resets, halt_ack}
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

    localparam int RW = 5;

    localparam logic [9:0] V_IDLE   = 10'b11111_1111_0;
    localparam logic [9:0] V_LU     = 10'b00111_1011_0;
    localparam logic [9:0] V_MDU    = 10'b00001_1110_0;
    localparam logic [9:0] V_BR     = 10'b11111_0011_0;
    localparam logic [9:0] V_JMP    = 10'b11111_0111_0;
    localparam logic [9:0] V_DRAIN  = 10'b01111_0111_0;
    localparam logic [9:0] V_HALTED = 10'b00000_1111_1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] ifid_rs;
    logic [RW-1:0] ifid_rt;
    logic          ifid_uses_rt;
    logic          ifid_jump;
    logic          idex_mem_read;
    logic [RW-1:0] idex_rt;
    logic          idex_mdu_start;
    logic          ex_branch_taken;
    logic          halt_req;
    logic          pc_enable;
    logic          ifid_enable;
    logic          idex_enable;
    logic          exmem_enable;
    logic          memwb_enable;
    logic          ifid_sync_reset;
    logic          idex_sync_reset;
    logic          exmem_sync_reset;
    logic          memwb_sync_reset;
    logic          halt_ack;

    hazard_stall_controller #(
        .MDU_LATENCY    (4),
        .DRAIN_CYCLES   (4),
        .REG_ADDR_WIDTH (RW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ifid_rs          (ifid_rs),
        .ifid_rt          (ifid_rt),
        .ifid_uses_rt     (ifid_uses_rt),
        .ifid_jump        (ifid_jump),
        .idex_mem_read    (idex_mem_read),
        .idex_rt          (idex_rt),
        .idex_mdu_start   (idex_mdu_start),
        .ex_branch_taken  (ex_branch_taken),
        .halt_req         (halt_req),
        .pc_enable        (pc_enable),
        .ifid_enable      (ifid_enable),
        .idex_enable      (idex_enable),
        .exmem_enable     (exmem_enable),
        .memwb_enable     (memwb_enable),
        .ifid_sync_reset  (ifid_sync_reset),
        .idex_sync_reset  (idex_sync_reset),
        .exmem_sync_reset (exmem_sync_reset),
        .memwb_sync_reset (memwb_sync_reset),
        .halt_ack         (halt_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } item_t;

    item_t sb[$];
    item_t mon_item;
    int    checks = 0;
    int    errors = 0;

    logic [9:0] act;
    assign act = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                  ifid_sync_reset, idex_sync_reset, exmem_sync_reset,
                  memwb_sync_reset, halt_ack};

    // Monitor: outputs are combinational, so each cycle presents one vector.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            checks++;
            if (act !== mon_item.exp) begin
                errors++;
                $display("FAIL %s: got %b, expected %b", mon_item.name, act, mon_item.exp);
            end
        end
    end

    task automatic clear_inputs();
        ifid_rs         = '0;
        ifid_rt         = '0;
        ifid_uses_rt    = 1'b0;
        ifid_jump       = 1'b0;
        idex_mem_read   = 1'b0;
        idex_rt         = '0;
        idex_mdu_start  = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic set_load(input logic [RW-1:0] dst, input logic [RW-1:0] rs);
        idex_mem_read = 1'b1;
        idex_rt       = dst;
        ifid_rs       = rs;
    endtask

    // Called just after a rising edge with the inputs for this cycle set.
    task automatic cyc(input logic [9:0] exp, input string name);
        item_t it;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        halt_req = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        cyc(V_IDLE, "reset_state");
        reset = 1'b1;
        cyc(V_IDLE, "idle");

        // Load-use: exactly one bubble.
        set_load(5'd5, 5'd5);
        cyc(V_LU, "load_use");
        clear_inputs();
        cyc(V_IDLE, "load_use_one_bubble");

        // Load into r0 never stalls.
        set_load(5'd0, 5'd0);
        cyc(V_IDLE, "load_r0_no_stall");
        clear_inputs();

        // Jump; rt match ignored because ID does not read rt.
        set_load(5'd7, 5'd3);
        ifid_rt   = 5'd7;
        ifid_jump = 1'b1;
        cyc(V_JMP, "jump_no_lu");
        ifid_uses_rt = 1'b1;
        cyc(V_LU, "lu_over_jump");
        clear_inputs();
        cyc(V_IDLE, "after_jump");

        // Branch outranks load-use.
        set_load(5'd5, 5'd5);
        ex_branch_taken = 1'b1;
        cyc(V_BR, "branch_over_lu");
        clear_inputs();

        // MDU held: 3 stall cycles then release.
        idex_mdu_start = 1'b1;
        cyc(V_MDU, "mdu_stall1");
        cyc(V_MDU, "mdu_stall2");
        cyc(V_MDU, "mdu_stall3");
        cyc(V_IDLE, "mdu_release");
        clear_inputs();
        cyc(V_IDLE, "mdu_back_run");

        // MDU outranks a (decoder-illegal) simultaneous branch.
        idex_mdu_start  = 1'b1;
        ex_branch_taken = 1'b1;
        cyc(V_MDU, "mdu_over_branch");
        ex_branch_taken = 1'b0;
        cyc(V_MDU, "mdu_b_stall2");
        cyc(V_MDU, "mdu_b_stall3");
        cyc(V_IDLE, "mdu_b_release");
        clear_inputs();

        // Reset during MDU_BUSY with two stall cycles pending.
        idex_mdu_start = 1'b1;
        cyc(V_MDU, "mdu_before_reset");
        idex_mdu_start = 1'b0;
        reset          = 1'b0;
        cyc(V_IDLE, "reset_mid_mdu");
        reset = 1'b1;
        cyc(V_IDLE, "reset_release");
        cyc(V_IDLE, "no_residual_stall");

        // Halt with one load-use stall inside the drain.
        halt_req = 1'b1;
        cyc(V_IDLE, "halt_enter");
        cyc(V_DRAIN, "drain1");
        set_load(5'd9, 5'd9);
        cyc(V_LU, "drain_load_use");
        clear_inputs();
        cyc(V_DRAIN, "drain2");
        cyc(V_DRAIN, "drain3");
        cyc(V_DRAIN, "drain4");
        cyc(V_HALTED, "halted");
        cyc(V_HALTED, "halted_hold");
        halt_req = 1'b0;
        cyc(V_HALTED, "halt_drop");
        cyc(V_IDLE, "resume");

        // Halt request dropped mid-drain; branch inside drain still counts.
        halt_req = 1'b1;
        cyc(V_IDLE, "halt2_enter");
        halt_req        = 1'b0;
        ex_branch_taken = 1'b1;
        cyc(V_BR, "drain_branch");
        clear_inputs();
        cyc(V_DRAIN, "drain_ignore_drop2");
        cyc(V_DRAIN, "drain_ignore_drop3");
        cyc(V_DRAIN, "drain_ignore_drop4");
        cyc(V_HALTED, "halted2");
        cyc(V_IDLE, "resume2");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
